// File: rtl/fifo_frame_reader.sv
// Reads FRAME_LEN samples from a standard-mode FIFO and streams them as complex AXI-Stream beats.
// Optional FIFO underrun zero padding is enabled by defining FIFO_FRAME_READER_ZERO_PAD_EN.
//
//   state | meaning
//   IDLE  | waiting for i_start
//   RUN   | issuing FIFO reads for the current frame
//   FLUSH | all reads issued, draining the skid buffer until the tlast beat transfers
module fifo_frame_reader #(
    parameter int DATA_WIDTH = 14,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAME_LEN  = 128,
    parameter int CONTINUOUS = 0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [DATA_WIDTH-1:0]  i_dout,
    input  logic                   i_empty,
    output logic                   o_rd_en,
    input  logic                   i_s_axis_tready,
    output logic                   o_s_axis_tvalid,
    output logic                   o_s_axis_tlast,
    output logic [2*OUT_WIDTH-1:0] o_s_axis_tdata,
    output logic                   o_busy,
    output logic                   o_frame_done,
    output logic [15:0]            o_frame_cnt
);

    localparam int            CW   = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LEN  = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
    localparam logic          CONT = (CONTINUOUS != 0);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_issued;
    logic [CW-1:0]        r_beat;
    logic                 r_inflight;
    logic                 r_stop;
    logic [1:0]           r_occ;
    logic [OUT_WIDTH-1:0] r_buf0;
    logic [OUT_WIDTH-1:0] r_buf1;
    logic                 r_frame_done;
    logic [15:0]          r_frame_cnt;

    logic                 w_xfer;
    logic                 w_tlast;
    logic                 w_frame_end;
    logic                 w_stop_pend;
    logic                 w_cont_next;
    logic                 w_can_issue;
    logic [2:0]           w_pending;
    logic                 w_rd;
    logic                 w_pad;
    logic                 w_issue;
    logic                 w_wr;
    logic [OUT_WIDTH-1:0] w_sext;
    logic [OUT_WIDTH-1:0] w_wdata;

    assign o_s_axis_tvalid = (r_occ != 2'd0);
    assign w_tlast         = (r_beat == LAST);
    assign o_s_axis_tlast  = o_s_axis_tvalid & w_tlast;
    assign o_s_axis_tdata  = {r_buf0, {OUT_WIDTH{1'b0}}};
    assign o_busy          = (r_state != IDLE);
    assign o_frame_done    = r_frame_done;
    assign o_frame_cnt     = r_frame_cnt;

    assign w_xfer      = o_s_axis_tvalid & i_s_axis_tready;
    assign w_frame_end = w_xfer & o_s_axis_tlast & (r_state == FLUSH);
    assign w_stop_pend = r_stop | (i_stop & CONT);
    // Next frame's first read may overlap the cycle the previous tlast transfers
    assign w_cont_next = CONT & w_frame_end & ~w_stop_pend;
    assign w_can_issue = ((r_state == RUN) & (r_issued != LEN)) | w_cont_next;

    // Occupancy after this cycle's transfer plus the read already in flight
    assign w_pending = {1'b0, r_occ} - {2'b00, w_xfer} + {2'b00, r_inflight};
    assign w_rd      = ~i_rst & ~i_empty & w_can_issue & (w_pending < 3'd2);
    assign o_rd_en   = w_rd;

`ifdef FIFO_FRAME_READER_ZERO_PAD_EN
    assign w_pad = ~i_rst & (r_state == RUN) & (r_issued != LEN) & i_empty &
                   ~r_inflight & (r_occ == 2'd0);
`else
    assign w_pad = 1'b0;
`endif

    assign w_issue = w_rd | w_pad;
    assign w_sext  = OUT_WIDTH'($signed(i_dout));
    assign w_wr    = r_inflight | w_pad;
    assign w_wdata = r_inflight ? w_sext : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_issued     <= '0;
            r_beat       <= '0;
            r_inflight   <= 1'b0;
            r_stop       <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_inflight   <= w_rd;
            r_frame_done <= 1'b0;
            if (w_xfer)
                r_beat <= w_tlast ? '0 : r_beat + 1'b1;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state  <= RUN;
                        r_issued <= '0;
                        r_beat   <= '0;
                        r_stop   <= 1'b0;
                    end
                end
                RUN: begin
                    if (i_stop & CONT)
                        r_stop <= 1'b1;
                    if (w_issue) begin
                        r_issued <= r_issued + 1'b1;
                        if (r_issued == LAST)
                            r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (i_stop & CONT)
                        r_stop <= 1'b1;
                    if (w_frame_end) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                        r_stop       <= 1'b0;
                        if (w_cont_next) begin
                            r_state  <= RUN;
                            r_issued <= w_rd ? CW'(1) : '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; r_buf0 is always the head presented on tdata
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_wr, w_xfer})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= w_wdata;
                        r_occ  <= 2'd1;
                    end else begin
                        r_buf1 <= w_wdata;
                        r_occ  <= 2'd2;
                    end
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= w_wdata;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_wdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fifo_frame_reader.md
FIFO_FRAME_READER -- requirements
Module: fifo_frame_reader

Interface
REQ-001 Parameter DATA_WIDTH, 14, sample width read from FIFO (signed two's complement).
REQ-002 Parameter OUT_WIDTH, 16, width of each of re/im fields on output stream; SHALL be >= DATA_WIDTH.
REQ-003 Parameter FRAME_LEN, 128, samples per frame; range 2..65535.
REQ-004 Parameter CONTINUOUS, 0, 0 = one frame per start; 1 = back-to-back frames until stop.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle frame request; sampled only in IDLE.
REQ-008 stop  input  1  single-cycle; in CONTINUOUS=1 ends streaming after current frame.
REQ-009 dout  input  DATA_WIDTH  FIFO read data; valid exactly 1 cycle after rd_en (standard-mode FIFO).
REQ-010 empty  input  1  FIFO empty flag.
REQ-011 rd_en  output  1  FIFO read strobe.
REQ-012 s_axis_tready  input  1  downstream (FFT) ready.
REQ-013 s_axis_tvalid  output  1  output beat valid.
REQ-014 s_axis_tlast  output  1  marks last beat of frame.
REQ-015 s_axis_tdata  output  2*OUT_WIDTH  {sign-extended sample (re, upper half), OUT_WIDTH zeros (im, lower half)}.
REQ-016 busy  output  1  high whenever state != IDLE.
REQ-017 frame_done  output  1  one-cycle pulse on the cycle after the tlast beat transfers.
REQ-018 frame_cnt  output  16  completed-frame count, wraps 0xFFFF -> 0.

Function
REQ-019 States: IDLE, RUN, FLUSH; IDLE->RUN on start; RUN->FLUSH when FRAME_LEN reads issued; FLUSH->IDLE (or ->RUN if CONTINUOUS=1 and no stop pending) when tlast beat transfers.
REQ-020 Output path SHALL be a 2-entry skid buffer; rd_en = (state==RUN) & !empty & (issued < FRAME_LEN) & (occupancy + in-flight reads < 2).
REQ-021 Data returned from FIFO SHALL be written into skid buffer the cycle after rd_en, never dropped.
REQ-022 s_axis_tvalid = skid buffer non-empty; beat transfers on tvalid & tready; tdata/tlast SHALL hold stable while tvalid & !tready.
REQ-023 With tready held high and FIFO non-empty, throughput SHALL be 1 beat/clk; first tvalid 2 cycles after start accepted.
REQ-024 s_axis_tlast high only on beat index FRAME_LEN-1 of each frame (index counted from 0 at frame start).
REQ-025 Simultaneous write and transfer in the skid buffer SHALL keep occupancy unchanged.
REQ-026 Issue and beat counters width $clog2(FRAME_LEN+1); both clear at each frame start.
REQ-027 start while busy SHALL be ignored; stop in IDLE or with CONTINUOUS=0 SHALL be ignored; stop latched until frame end.
REQ-028 Continuous mode: next frame's first read may issue in the cycle the previous tlast transfers; no bubble required beyond skid occupancy limits.
REQ-029 frame_cnt increments by 1 coincident with frame_done pulse.

Reset
REQ-030 rst SHALL force IDLE and clear: rd_en=0, s_axis_tvalid=0, s_axis_tlast=0, s_axis_tdata=0, busy=0, frame_done=0, frame_cnt=0, skid buffer, counters, stop latch.
REQ-031 rst mid-frame SHALL abort immediately; read data returning the cycle after rst is discarded; no partial tlast emitted.

Configuration
REQ-032 Macro FIFO_FRAME_READER_ZERO_PAD_EN: when defined, in RUN with empty=1, no read in flight and skid buffer empty, one zero sample SHALL be injected per cycle into the skid buffer and counted as issued, so a frame never stalls on FIFO underrun.
REQ-033 Without FIFO_FRAME_READER_ZERO_PAD_EN, underrun SHALL stall the frame (tvalid low) until FIFO non-empty; no zeros inserted.

Verification
REQ-034 FIFO preloaded 128 ramp samples 0..127, start, tready=1 -> 128 consecutive beats, re = sample, im = 0, tlast on beat 127, frame_done 1 cycle later, frame_cnt=1.
REQ-035 Sample 14'h2000 (-8192) -> s_axis_tdata[31:16] = 16'hE000, [15:0] = 0.
REQ-036 tready toggled 1/0 every cycle, 128 samples -> all 128 delivered in order, none lost/duplicated, tdata stable while stalled, never >2 reads outstanding.
REQ-037 CONTINUOUS=1, 384 samples, start, stop during second frame -> exactly 2 frames, tlast on beats 127 and 255, frame_cnt=2, IDLE after.
REQ-038 FIFO holds 100 samples, start: pad build -> beats 100..127 zero, tlast on 127; non-pad build -> tvalid low after 100 beats, completes after 28 more writes.
REQ-039 rst asserted at beat 50 -> next cycle tvalid=0, busy=0, frame_cnt=0; subsequent start yields a full, correct frame.
